fir_share_ctrl: RTL and testbench

- Frame-granular scheduler that shares one transposed-form multiplierless FIR datapath (10-register delay chain, approximate adders) between two streaming requesters.
- Grants the FIR to one requester per frame, using round-robin, and gates the FIR delay-line update with fir_en.
- After every frame, and after reset, injects zero samples so filter state never leaks between frames or requesters.
- Sits between the requester sources and the FIR instance. Tags each FIR output with requester id and frame end.

---
 rtl/fir_share_ctrl.sv | 113 +++++++++++
 tb/tb_fir_share_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_share_ctrl.sv
// fir_share_ctrl: frame-granular round-robin scheduler sharing one FIR datapath between two requesters
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/data/last/ready  requester N sample stream (N = 0, 1)
//   fir_x, fir_en, fir_y        FIR sample input, delay-line update enable, FIR output
//   out_valid/data/id/last      filtered sample tagged with owner and frame end
//   busy                        scheduler is not idle
module fir_share_ctrl #(
    parameter int DATA_W    = 32,
    parameter int FLUSH_LEN = 9,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic [DATA_W-1:0] fir_x,
    output logic              fir_en,
    input  logic [DATA_W-1:0] fir_y,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    output logic              out_last,
    output logic              busy
);
    typedef enum logic [1:0] {INIT, IDLE, STREAM, FLUSH} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_q, grant_d, rr_q, rr_d;
    logic               out_valid_q, out_id_q, out_last_q;
    logic               g_valid, g_last;
    logic [DATA_W-1:0]  g_data;
    assign g_valid = grant_q ? req1_valid : req0_valid;
    assign g_last  = grant_q ? req1_last  : req0_last;
    assign g_data  = grant_q ? req1_data  : req0_data;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        fir_x      = '0;
        fir_en     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            INIT: begin
                // zero-fill the unreset FIR delay line once after reset
                fir_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    grant_d = (req0_valid & req1_valid) ? rr_q : req1_valid;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // ready depends on state only, so a transfer is simply the granted valid
                req0_ready = ~grant_q;
                req1_ready = grant_q;
                fir_en     = g_valid;
                fir_x      = g_valid ? g_data : '0;
                if (g_valid & g_last) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_LEN);
                end
            end
            FLUSH: begin
                fir_en = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    rr_d    = ~grant_q;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            // init flushing clocks the FIR but produces no outputs
            out_valid_q <= fir_en & (state_q != INIT);
            out_id_q    <= grant_q;
            out_last_q  <= (state_q == FLUSH) && (cnt_q == CNT_W'(1));
        end
    end
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;
    assign out_data  = fir_y;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_fir_share_ctrl.sv
// tb_fir_share_ctrl: randomized scoreboard bench for fir_share_ctrl with a behavioural FIR and convolution reference
module tb_fir_share_ctrl;
    localparam int FL = 9;
    typedef struct { logic [31:0] d; logic l; int gap; } item_t;
    typedef struct { logic [31:0] d; logic id; logic last; } exp_t;
    logic clk = 0, rst_n = 0;
    logic req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
    logic [31:0] req0_data, req1_data, fir_x, fir_y, out_data;
    logic fir_en, out_valid, out_id, out_last, busy;
    item_t tx0[$], tx1[$], m0[$], m1[$];
    exp_t sb[$];
    int checks = 0, errors = 0;
    logic exp_rr = 0;
    int h [10] = '{7, -3, 12, 5, -9, 4, 11, -2, 6, 0};
    logic [31:0] fr [10] = '{32'hdead0001, 32'h1234, 32'h55aa55aa, 32'h7, 32'hffff0000,
                             32'h0badf00d, 32'h99, 32'h31337, 32'hcafe, 32'h42};
    always #5 clk = ~clk;
    fir_share_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .fir_x(fir_x), .fir_en(fir_en), .fir_y(fir_y),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last), .busy(busy)
    );
    // stand-in transposed-form FIR with unreset registers
    always @(posedge clk) begin
        if (fir_en) begin
            for (int k = 0; k < 9; k++) fr[k] <= fr[k+1] + fir_x * 32'(h[k]);
            fr[9] <= fir_x * 32'(h[9]);
        end
    end
    assign fir_y = fr[0];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic void push_conv(input int r, input logic [31:0] s[$], input int nout);
        int L;
        logic [31:0] y;
        L = s.size();
        for (int n = 0; n < nout; n++) begin
            y = 0;
            for (int k = 0; k < 10; k++)
                if (n - k >= 0 && n - k < L) y = y + s[n-k] * 32'(h[k]);
            sb.push_back(exp_t'{d: y, id: (r != 0), last: (n == L + FL - 1)});
        end
    endfunction
    function automatic void add(input int r, input logic [31:0] s[$], input int gap_at, input int gap_len);
        item_t it;
        for (int i = 0; i < s.size(); i++) begin
            it.d = s[i];
            it.l = (i == s.size() - 1);
            it.gap = (i == gap_at) ? gap_len : 0;
            if (r != 0) begin tx1.push_back(it); m1.push_back(it); end
            else begin tx0.push_back(it); m0.push_back(it); end
        end
    endfunction
    // frame-level arbitration: contention goes to the preferred requester, preference flips to the other side after each frame
    function automatic void model();
        int r;
        item_t it;
        logic [31:0] s[$];
        while (m0.size() > 0 || m1.size() > 0) begin
            r = (m0.size() > 0 && m1.size() > 0) ? int'(exp_rr) : (m1.size() > 0 ? 1 : 0);
            s.delete();
            do begin
                it = (r != 0) ? m1.pop_front() : m0.pop_front();
                s.push_back(it.d);
            end while (!it.l);
            push_conv(r, s, s.size() + FL);
            exp_rr = (r == 0);
        end
    endfunction
    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && tx0.size() == 0 && tx1.size() == 0 && !busy) begin ok = 1; break; end
        end
        chk("wait_idle", ok, 1);
    endtask
    task automatic check_init();
        int n = 0, bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (!(fir_en && fir_x == 0 && !out_valid)) bad++;
            n++;
        end
        chk("init_cycles", n, 9);
        chk("init_bad", bad, 0);
        chk("idle_ready", {req0_ready, req1_ready}, 0);
    endtask
    initial begin : drv0
        int gap; bit x; item_t it;
        gap = 0; x = 0;
        req0_valid = 0; req0_data = 0; req0_last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin req0_valid = 0; tx0.delete(); gap = 0; x = 0; end
            else begin
                if (x) begin it = tx0.pop_front(); gap = it.gap; end
                if (gap > 0) begin req0_valid = 0; gap--; end
                else if (tx0.size() > 0) begin req0_valid = 1; req0_data = tx0[0].d; req0_last = tx0[0].l; end
                else req0_valid = 0;
                x = req0_valid & req0_ready;
            end
        end
    end
    initial begin : drv1
        int gap; bit x; item_t it;
        gap = 0; x = 0;
        req1_valid = 0; req1_data = 0; req1_last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin req1_valid = 0; tx1.delete(); gap = 0; x = 0; end
            else begin
                if (x) begin it = tx1.pop_front(); gap = it.gap; end
                if (gap > 0) begin req1_valid = 0; gap--; end
                else if (tx1.size() > 0) begin req1_valid = 1; req1_data = tx1[0].d; req1_last = tx1[0].l; end
                else req1_valid = 0;
                x = req1_valid & req1_ready;
            end
        end
    end
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) chk("unexpected_out_valid", out_valid, 0);
                else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_id", out_id, e.id);
                    chk("out_last", out_last, e.last);
                end
            end
        end
    end
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin : main
        logic [31:0] fq[$];
        int len, n0, n1, ga;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        check_init();
        // contention twice: requester 0 first both times
        fq = {32'd3, 32'd4}; add(0, fq, -1, 0);
        fq = {32'd10, 32'd20, 32'd30}; add(1, fq, -1, 0);
        model(); wait_idle();
        fq = {32'd100}; add(0, fq, -1, 0);
        fq = {32'd200, 32'd1}; add(1, fq, -1, 0);
        model(); wait_idle();
        // impulse response
        fq = {32'd1, 32'd0, 32'd0}; add(0, fq, -1, 0);
        model(); wait_idle();
        // stalled frame
        fq = {32'd5, 32'd7, 32'd9, 32'd11}; add(0, fq, 1, 3);
        model();
        for (int i = 0; i < 50; i++) begin @(negedge clk); #1; if (tx0.size() <= 2) break; end
        for (int i = 0; i < 3; i++) begin
            chk("stall_fir_en", fir_en, 0);
            chk("stall_fir_x", fir_x, 0);
            @(negedge clk); #1;
        end
        wait_idle();
        // saturated frame then a clean impulse from the other requester
        fq = {32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff};
        add(0, fq, -1, 0); model(); wait_idle();
        fq = {32'd1}; add(1, fq, -1, 0); model(); wait_idle();
        // reset in the middle of a frame
        fq = {32'd21, 32'd22, 32'd23, 32'd24, 32'd25};
        add(0, fq, -1, 0);
        m0.delete();
        push_conv(0, fq, 2);
        for (int i = 0; i < 50; i++) begin @(negedge clk); #1; if (tx0.size() <= 3) break; end
        #2 rst_n = 0;
        #1;
        chk("midrst_ready0", req0_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_partial_outs", sb.size(), 0);
        sb.delete();
        exp_rr = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1;
        check_init();
        add(0, fq, -1, 0); model(); wait_idle();
        // randomized rounds, including back-to-back frames and contention
        for (int rd = 0; rd < 12; rd++) begin
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 + n1 == 0) n0 = 1;
            for (int f = 0; f < n0 + n1; f++) begin
                len = $urandom_range(1, 6);
                fq.delete();
                for (int i = 0; i < len; i++)
                    fq.push_back($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 9)));
                ga = $urandom_range(0, len - 1);
                add((f < n0) ? 0 : 1, fq, ga, (ga == len - 1) ? 0 : $urandom_range(0, 3));
            end
            model();
            wait_idle();
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
